// File: rtl/dm_share_arbiter.sv
// rtl/dm_share_arbiter.sv - round-robin arbiter sharing one data memory among cores
module dm_share_arbiter #(
  parameter int N_CORES = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CORES-1:0]    req,
  input  logic [N_CORES-1:0]    we,
  input  logic [N_CORES*AW-1:0] addr,
  input  logic [N_CORES*DW-1:0] wdata,
  input  logic [N_CORES-1:0]    end_process,
  output logic [N_CORES-1:0]    gnt,
  output logic [N_CORES-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic                  mem_we,
  input  logic [DW-1:0]         mem_rdata,
  output logic [N_CORES-1:0]    done_mask,
  output logic                  all_done
);

  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      g;
  logic               found;
  logic [N_CORES-1:0] eligible;
  logic [N_CORES-1:0] gnt_int;
  logic [N_CORES-1:0] done_next;
  int                 idx;

  assign eligible  = req & ~done_mask;
  assign done_next = done_mask | end_process;

  // Search eligible cores starting at ptr, wrapping; first hit wins
  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = 0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        g     = PW'(idx);
      end
    end
  end

  // One-hot grant, suppressed while reset is asserted; idle cycles route core 0's fields
  always_comb begin
    gnt_int   = found ? (N_CORES'(1) << g) : '0;
    gnt       = rst_n ? gnt_int : '0;
    mem_addr  = addr[int'(g)*AW +: AW];
    mem_wdata = wdata[int'(g)*DW +: DW];
    mem_we    = rst_n & found & we[g];
  end

  assign rdata = mem_rdata;

  // Advance the round-robin pointer past the granted core
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(g) == N_CORES - 1) ? '0 : g + 1'b1;
    end
  end

  // Read return flag one cycle after a read grant; reset drops any in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
    end else begin
      rvalid <= (found && !we[g]) ? gnt_int : '0;
    end
  end

  // Sticky completion flags; the mask only affects arbitration from the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_mask <= '0;
      all_done  <= 1'b0;
    end else begin
      done_mask <= done_next;
      all_done  <= &done_next;
    end
  end

endmodule
